// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART constants for the receiver and transmitter: frame format,
// receiver FSM state encoding and bit-time divider derivation.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    // Frame format shared by receiver and transmitter (8N1).
    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_STOP_BITS  = 1;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Clock cycles per serial bit.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Half a bit time; used to land the start-bit check mid-bit.
    function automatic int calc_half_div(input int clk_hz, input int baud);
        return (clk_hz / baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// First-word fall-through receive buffer. A push while full is accepted only
// if a pop happens in the same cycle; a pop while empty is ignored.
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   push, din         write request and data
//   pop               remove head entry
//   dout              head entry (zero while empty)
//   empty, full       occupancy status
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Accept/remove decisions and next pointer/count values.
    always_comb begin
        do_pop_s  = pop && (count_q != CNT_ZERO);
        // A full buffer can still take a byte when the head leaves this cycle.
        do_push_s = push && ((count_q != CNT_MAX) || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign empty = (count_q == CNT_ZERO);
    assign full  = (count_q == CNT_MAX);
    assign dout  = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 serial receiver with a small FWFT receive buffer and sticky error flags.
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   rxd           asynchronous serial input (idle high, LSB first)
//   rd_en         pop head byte (CPU read of data register)
//   clr_err       clear sticky overrun / frame_err
//   rdata         head byte of the buffer
//   valid         buffer non-empty
//   overrun       sticky: a received byte was dropped (buffer full)
//   frame_err     sticky: stop bit sampled low
// -----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10000000,
    parameter int BAUD_RATE   = 1000000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rdata,
    output logic       valid,
    output logic       overrun,
    output logic       frame_err
);

    localparam int DIV      = calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int HALF_DIV = calc_half_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic sync1_q;
    logic sync2_q;
    logic rx_prev_q;
    logic rx_s;

    rx_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;

    logic       cnt_zero_s;
    logic       push_s;
    logic       frame_set_s;
    logic       ovr_set_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic [7:0] fifo_dout_s;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q   <= UART_IDLE_LEVEL;
            sync2_q   <= UART_IDLE_LEVEL;
            rx_prev_q <= UART_IDLE_LEVEL;
        end else begin
            sync1_q   <= rxd;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    assign rx_s = sync2_q;

    // Receiver FSM: next state, bit timer, bit index, shifter and push strobe.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        push_s      = 1'b0;
        frame_set_s = 1'b0;
        cnt_zero_s  = (cnt_q == CNT_ZERO);
        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cnt_zero_s) begin
                    // Line back high at mid-start-bit means a glitch, not a frame.
                    if (!rx_s) begin
                        cnt_d   = CNT_FULL;
                        idx_d   = 3'd0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_zero_s) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = CNT_FULL;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_zero_s) begin
                    if (rx_s) begin
                        push_s = 1'b1;
                    end else begin
                        frame_set_s = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky error flags; a set event in the same cycle beats clr_err.
    always_comb begin
        ovr_set_s = push_s && fifo_full_s && !rd_en;
        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (clr_err) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        if (frame_set_s) begin
            frame_err_d = 1'b1;
        end else if (clr_err) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
    end

    // FSM, datapath and flag registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_s),
        .pop    (rd_en),
        .din    (shift_q),
        .dout   (fifo_dout_s),
        .empty  (fifo_empty_s),
        .full   (fifo_full_s)
    );

    assign rdata     = fifo_dout_s;
    assign valid     = !fifo_empty_s;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 10000000, clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 1000000, serial bit rate; DIV = CLK_FREQ_HZ/BAUD_RATE (integer, >=4).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive buffer entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port rd_en  input  1  pop head byte from FIFO (CPU read of data register).
REQ-008 SHALL have port clr_err  input  1  clear sticky error flags.
REQ-009 SHALL have port rdata  output  8  FIFO head byte, first-word fall-through.
REQ-010 SHALL have port valid  output  1  FIFO non-empty.
REQ-011 SHALL have port overrun  output  1  sticky: byte dropped because FIFO full.
REQ-012 SHALL have port frame_err  output  1  sticky: stop bit sampled low.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer; all decoding uses the synchronized value rx_s.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP with a bit-time down-counter and 3-bit bit index.
REQ-015 IDLE: on rx_s falling edge (previous 1, current 0), load counter DIV/2-1, go START.
REQ-016 START: at counter 0 sample rx_s; if 0 load DIV-1, index 0, go DATA; if 1 (glitch) go IDLE, nothing recorded.
REQ-017 DATA: at each counter 0 shift rx_s into shift register MSB, shifting right (LSB first), reload DIV-1; after index 7 go STOP.
REQ-018 STOP: at counter 0 sample rx_s; if 1 push byte; if 0 set frame_err, discard byte; go IDLE in both cases.
REQ-019 Push while FIFO full and rd_en low SHALL drop the new byte, set overrun, and leave FIFO contents unchanged.
REQ-020 Push and rd_en in the same cycle while full SHALL pop head and accept the new byte, with no overrun.
REQ-021 rd_en while empty SHALL be ignored, with no pointer or count change.
REQ-022 Pushed byte SHALL appear on rdata with valid high on the cycle after the stop-bit sample.
REQ-023 rd_en pop SHALL present the next entry (or deassert valid) on the following cycle; pointers wrap modulo FIFO_DEPTH.
REQ-024 clr_err SHALL clear both sticky flags next cycle; a same-cycle set event SHALL win over clr_err.
REQ-025 Receiver timing SHALL be independent of FIFO reads; reception never stalls.

Reset
REQ-026 resetn low SHALL force FSM to IDLE and clear counter, index, shift register, FIFO pointers and count.
REQ-027 During reset, valid, overrun, frame_err SHALL be 0, rdata SHALL be 8'h00, and synchronizer flops SHALL be 1 (idle line).
REQ-028 Reset mid-frame SHALL discard the partial byte; the next falling edge after release SHALL start a new frame.

Structure
REQ-029 FSM state encoding and the DIV/half-DIV derivation SHALL live in a shared package uart_pkg, alongside the transmitter's constants.
REQ-030 FIFO SHALL be a separate sub-module uart_rx_fifo (push, pop, din, dout, empty, full), parameterized by depth and width.
REQ-031 SOC integration SHALL map rdata/valid into the IO page: data register read asserts rd_en; the status word carries valid, overrun and frame_err bits.

Verification (DIV=10, FIFO_DEPTH=4)
REQ-032 Send 0x55 as a clean 8N1 frame -> valid rises 96..100 clk after rxd falling edge, rdata=0x55, frame_err=0.
REQ-033 Send 0x41,0x42,0x43 back-to-back, no reads -> valid=1; pops return 0x41,0x42,0x43 in order, then valid=0.
REQ-034 Send 5 bytes 0x01..0x05 with no reads -> overrun=1; pops return 0x01..0x04; clr_err -> overrun=0.
REQ-035 Send frame 0xA5 with stop bit forced low -> frame_err=1, valid stays 0.
REQ-036 Pulse rxd low for 3 clk -> FSM returns to IDLE, valid=0, no flags set.
REQ-037 Assert resetn=0 after 4 data bits of 0xFF, release, send 0x3C -> only 0x3C received, no flags set.
